// File: rtl/set_job_scheduler.sv
// Two-requester round-robin job queue feeding a single SET engine.
// Jobs are issued one at a time, and each result is returned tagged with the id of the requester that sent it.
//  state  | meaning
//  IDLE   | waiting for a queued job and an idle engine; pops the FIFO head
//  ISSUE  | set_en pulse for one cycle
//  WAIT   | engine running; capture result on set_valid
//  RESP   | result presented until rsp_ready
module set_job_scheduler #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [23:0]              req0_central,
    input  logic [11:0]              req0_radius,
    input  logic [1:0]               req0_mode,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [23:0]              req1_central,
    input  logic [11:0]              req1_radius,
    input  logic [1:0]               req1_mode,
    output logic                     set_en,
    output logic [23:0]              set_central,
    output logic [11:0]              set_radius,
    output logic [1:0]               set_mode,
    input  logic                     set_busy,
    input  logic                     set_valid,
    input  logic [7:0]               set_candidate,
    output logic                     rsp_valid,
    output logic                     rsp_id,
    output logic [7:0]               rsp_candidate,
    input  logic                     rsp_ready,
    output logic [$clog2(DEPTH):0]   pending
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    logic [38:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          last_q, last_d;
    state_t        state_q, state_d;
    logic [38:0]   job_q, job_d;
    logic          rsp_id_q, rsp_id_d;
    logic [7:0]    rsp_cand_q, rsp_cand_d;

    logic          full, empty, grant0, grant1, push, pop;
    logic [38:0]   push_data;

    always_comb begin
        full       = (count_q == CW'(DEPTH));
        empty      = (count_q == '0);
        grant0     = req0_valid & (~req1_valid | last_q);
        grant1     = req1_valid & (~req0_valid | ~last_q);
        // Gated by reset so the ready outputs read 0 while rst is held.
        req0_ready = rst & grant0 & ~full;
        req1_ready = rst & grant1 & ~full;
        push       = (req0_valid & req0_ready) | (req1_valid & req1_ready);
        push_data  = req1_ready ? {1'b1, req1_mode, req1_radius, req1_central}
                                : {1'b0, req0_mode, req0_radius, req0_central};
        last_d     = push ? req1_ready : last_q;
    end

    always_comb begin
        state_d    = state_q;
        job_d      = job_q;
        rsp_id_d   = rsp_id_q;
        rsp_cand_d = rsp_cand_q;
        pop        = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!empty && !set_busy) begin
                    pop     = 1'b1;
                    job_d   = mem_q[rd_ptr_q];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (set_valid) begin
                    rsp_cand_d = set_candidate;
                    rsp_id_d   = job_q[38];
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset: occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            last_q     <= 1'b1;
            state_q    <= S_IDLE;
            job_q      <= '0;
            rsp_id_q   <= 1'b0;
            rsp_cand_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            last_q     <= last_d;
            state_q    <= state_d;
            job_q      <= job_d;
            rsp_id_q   <= rsp_id_d;
            rsp_cand_q <= rsp_cand_d;
        end
    end

    assign set_en        = (state_q == S_ISSUE);
    assign set_central   = job_q[23:0];
    assign set_radius    = job_q[35:24];
    assign set_mode      = job_q[37:36];
    assign rsp_valid     = (state_q == S_RESP);
    assign rsp_id        = rsp_id_q;
    assign rsp_candidate = rsp_cand_q;
    assign pending       = count_q;

endmodule

// File: tb/tb_set_job_scheduler.sv
// Scoreboard bench for set_job_scheduler with a SET stub: busy 5 cycles after en, then one valid cycle with candidate = central[7:0].
`timescale 1ns/1ps
module tb_set_job_scheduler;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [23:0] req0_central = '0, req1_central = '0;
    logic [11:0] req0_radius = '0, req1_radius = '0;
    logic [1:0]  req0_mode = '0, req1_mode = '0;
    logic        set_en;
    logic [23:0] set_central;
    logic [11:0] set_radius;
    logic [1:0]  set_mode;
    logic        set_busy, set_valid;
    logic [7:0]  set_candidate;
    logic        rsp_valid, rsp_id;
    logic [7:0]  rsp_candidate;
    logic        rsp_ready = 1'b0;
    logic [$clog2(DEPTH):0] pending;

    int vectors = 0;
    int miscompares = 0;
    logic [8:0] exp_q[$];

    set_job_scheduler #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_central(req0_central),
        .req0_radius(req0_radius), .req0_mode(req0_mode),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_central(req1_central),
        .req1_radius(req1_radius), .req1_mode(req1_mode),
        .set_en(set_en), .set_central(set_central), .set_radius(set_radius), .set_mode(set_mode),
        .set_busy(set_busy), .set_valid(set_valid), .set_candidate(set_candidate),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_candidate(rsp_candidate),
        .rsp_ready(rsp_ready), .pending(pending)
    );

    always #5 clk = ~clk;

    // SET stub, reset together with the scheduler
    logic [3:0] stub_cnt;
    logic [7:0] stub_lat;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            set_busy <= 1'b0; set_valid <= 1'b0; set_candidate <= '0;
            stub_cnt <= '0; stub_lat <= '0;
        end else begin
            set_valid <= 1'b0;
            if (set_en) begin
                stub_lat <= set_central[7:0];
                stub_cnt <= 4'd5;
                set_busy <= 1'b1;
            end else if (stub_cnt != 0) begin
                stub_cnt <= stub_cnt - 4'd1;
                if (stub_cnt == 4'd1) begin
                    set_busy      <= 1'b0;
                    set_valid     <= 1'b1;
                    set_candidate <= stub_lat;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare each response on its handshake
    always @(negedge clk) begin
        if (rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL rsp_unexpected: got id %0d cand %0h expected no response", rsp_id, rsp_candidate);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(e[8]));
                chk("rsp_candidate", 32'(rsp_candidate), 32'(e[7:0]));
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic id, input logic [23:0] c, input logic [11:0] r,
                        input logic [1:0] m, input logic push_exp);
        bit done;
        done = 1'b0;
        if (id) begin
            req1_central = c; req1_radius = r; req1_mode = m; req1_valid = 1'b1;
        end else begin
            req0_central = c; req0_radius = r; req0_mode = m; req0_valid = 1'b1;
        end
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if ((id && req1_ready) || (!id && req0_ready)) begin
                if (push_exp) exp_q.push_back({id, c[7:0]});
                done = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: got no ready expected accept for id %0d", id);
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (n < 400 && (exp_q.size() != 0 || rsp_valid || set_busy || pending != 0)) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_left"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_pending"}, 32'(pending), 32'd0);
    endtask

    initial begin
        int n, en_cnt, en_at, acc;
        logic exp_id;
        bit accepted;

        // reset values
        #2;
        chk("rst_req0_ready", 32'(req0_ready), 0);
        chk("rst_req1_ready", 32'(req1_ready), 0);
        chk("rst_set_en", 32'(set_en), 0);
        chk("rst_set_central", 32'(set_central), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_pending", 32'(pending), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // single job
        rsp_ready = 1'b1;
        send(1'b0, 24'h123456, 12'h345, 2'b01, 1'b1);
        @(negedge clk);
        chk("single_pending_q", 32'(pending), 1);
        @(negedge clk);
        chk("single_set_en", 32'(set_en), 1);
        chk("single_central", 32'(set_central), 32'h123456);
        chk("single_radius", 32'(set_radius), 32'h345);
        chk("single_mode", 32'(set_mode), 1);
        chk("single_pending_pop", 32'(pending), 0);
        n = 0; en_cnt = 0;
        while (!rsp_valid && n < 30) begin
            @(negedge clk);
            n++;
            if (set_en) en_cnt++;
        end
        chk("single_rsp_lat", 32'(n), 7);
        chk("single_extra_en", 32'(en_cnt), 0);
        drain("single_drain");

        // contention: both held valid, accepts alternate starting with 0
        do_reset();
        rsp_ready = 1'b1;
        req0_central = 24'h0000A1; req0_radius = 12'h111; req0_mode = 2'b11;
        req1_central = 24'h0000B2; req1_radius = 12'h222; req1_mode = 2'b10;
        req0_valid = 1'b1; req1_valid = 1'b1;
        exp_id = 1'b0; acc = 0;
        for (int c = 0; c < 300 && acc < 6; c++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                chk("cont_grant_id", 32'(req1_ready), 32'(exp_id));
                chk("cont_one_grant", 32'(req0_ready & req1_ready), 0);
                exp_q.push_back({exp_id, exp_id ? 8'hB2 : 8'hA1});
                exp_id = ~exp_id;
                acc++;
                if (acc == 6) begin
                    @(posedge clk);
                    #1;
                    req0_valid = 1'b0; req1_valid = 1'b0;
                end
            end
        end
        chk("cont_accepts", 32'(acc), 6);
        drain("cont_drain");

        // full FIFO and response backpressure
        do_reset();
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(1'b1, 24'h000010 + 24'(i), 12'h0AB, 2'b00, 1'b1);
        @(negedge clk);
        chk("full_pending", 32'(pending), 4);
        req1_central = 24'h000015; req1_valid = 1'b1;
        n = 0;
        while (!rsp_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("full_rsp_seen", 32'(rsp_valid), 1);
        for (int i = 0; i < 20; i++) begin
            chk("bp_rsp_valid", 32'(rsp_valid), 1);
            chk("bp_rsp_id", 32'(rsp_id), 1);
            chk("bp_rsp_cand", 32'(rsp_candidate), 32'h10);
            chk("bp_no_set_en", 32'(set_en), 0);
            chk("bp_req1_ready", 32'(req1_ready), 0);
            chk("bp_pending", 32'(pending), 4);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        en_at = -1; accepted = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (set_en && en_at < 0) en_at = k;
            if (req1_valid && req1_ready && !accepted) begin
                exp_q.push_back({1'b1, 8'h15});
                accepted = 1'b1;
                chk("full_accept_at", 32'(k), 3);
                @(posedge clk);
                #1;
                req1_valid = 1'b0;
            end
        end
        chk("bp_next_en_lat", 32'(en_at), 3);
        chk("full_sixth_accepted", 32'(accepted), 1);
        drain("full_drain");

        // reset while SET engine is busy
        send(1'b0, 24'h0000C3, 12'h0CD, 2'b10, 1'b0);
        n = 0;
        while (!set_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("mid_busy", 32'(set_busy), 1);
        #1;
        rst = 1'b0;
        req0_valid = 1'b1;
        #1;
        chk("mid_set_en", 32'(set_en), 0);
        chk("mid_set_central", 32'(set_central), 0);
        chk("mid_set_radius", 32'(set_radius), 0);
        chk("mid_set_mode", 32'(set_mode), 0);
        chk("mid_rsp_valid", 32'(rsp_valid), 0);
        chk("mid_rsp_id", 32'(rsp_id), 0);
        chk("mid_rsp_cand", 32'(rsp_candidate), 0);
        chk("mid_pending", 32'(pending), 0);
        chk("mid_req0_ready", 32'(req0_ready), 0);
        req0_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        send(1'b0, 24'h00005A, 12'h0EF, 2'b00, 1'b1);
        drain("mid_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
